alu_arbiter: RTL and testbench

Shares one combinational alu instance between two requesters (req0 = integer execute pipe, req1 = auxiliary unit, e.g. address-gen/CSR helper) using valid/ready handshakes and round-robin arbitration. The block accepts at most one operation per cycle. Each result is registered into a one-entry response buffer per requester, so the response arrives one cycle after acceptance.

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes and requester indices.
// Imported by the alu, the arbiter top and the arbiter bench.
package alu_arbiter_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1001;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit integer ALU shared by the arbiter's two requesters.
// Undefined control codes produce zero.
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      result = 32'd0;
      unique case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt;
         ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'd0, a < b};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         ALU_LUI:  result = b;
         default:  result = 32'd0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two valid/ready requesters,
// with a one-entry registered response buffer per requester.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int RESET_PRIORITY = 0,
   parameter int DATA_WIDTH     = 32
)
(
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [3:0]            req0_op,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_result,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   input  logic [3:0]            req1_op,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_result
);

   // last_grant starts on the "other" requester so RESET_PRIORITY wins the first contest
   localparam logic LAST_GRANT_INIT = (RESET_PRIORITY == 0) ? REQ1 : REQ0;

   logic                  eligible0;
   logic                  eligible1;
   logic                  grant0;
   logic                  grant1;
   logic                  last_grant;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [3:0]            alu_op;
   logic [DATA_WIDTH-1:0] alu_result;

   // A full buffer only blocks its requester if it is not being drained this cycle
   always_comb begin
      eligible0 = req0_valid && (!rsp0_valid || rsp0_ready);
      eligible1 = req1_valid && (!rsp1_valid || rsp1_ready);
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (rst_n) begin
         if (eligible0 && eligible1) begin
            grant0 = (last_grant == REQ1);
            grant1 = (last_grant == REQ0);
         end else begin
            grant0 = eligible0;
            grant1 = eligible1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign alu_a  = grant1 ? req1_a  : req0_a;
   assign alu_b  = grant1 ? req1_b  : req0_b;
   assign alu_op = grant1 ? req1_op : req0_op;

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LAST_GRANT_INIT;
      end else if (grant0) begin
         last_grant <= REQ0;
      end else if (grant1) begin
         last_grant <= REQ1;
      end
   end

   // Accept wins over drain, so a draining buffer refills with no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
      end else if (grant0) begin
         rsp0_valid  <= 1'b1;
         rsp0_result <= alu_result;
      end else if (rsp0_valid && rsp0_ready) begin
         rsp0_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
      end else if (grant1) begin
         rsp1_valid  <= 1'b1;
         rsp1_result <= alu_result;
      end else if (rsp1_valid && rsp1_ready) begin
         rsp1_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic
// checked against a behavioural model of arbitration and the ALU function.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_result, rsp1_result;

   int tests  = 0;
   int failed = 0;

   alu_arbiter #(.RESET_PRIORITY(0), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_op     (req0_op),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_result (rsp0_result),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_op     (req1_op),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_result (rsp1_result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << sh;
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return $unsigned($signed(a) >>> sh);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         ALU_LUI:  return b;
         default:  return 32'd0;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge, then settle before checks
   task automatic apply_stimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] op0, input logic v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [3:0] op1,
                                 input logic rr0, input logic rr1);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      rsp0_ready = rr0; rsp1_ready = rr1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus(0, 0, 0, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 1);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   logic [3:0]  op_list [0:11] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                                   ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, 4'b1111};
   logic [31:0] ca0, cb0, ca1, cb1;
   logic        pend_v [2];
   logic [31:0] pend_a [2], pend_b [2];
   logic [3:0]  pend_op [2];
   logic        full [2];
   logic [31:0] data [2];
   logic        rr [2];
   logic        elig [2];
   int          last;
   int          win;

   initial begin
      // Reset state, including ready held low while reset is asserted
      apply_stimulus(1, 5, 7, ALU_ADD, 1, 1, 1, ALU_ADD, 1, 1);
      check_output("reset_req0_ready", 32'(req0_ready), 32'd0);
      check_output("reset_req1_ready", 32'(req1_ready), 32'd0);
      do_reset();
      check_output("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check_output("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
      check_output("reset_rsp0_result", rsp0_result, 32'd0);
      check_output("reset_rsp1_result", rsp1_result, 32'd0);

      // Single request
      tick();
      apply_stimulus(1, 5, 7, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 1);
      check_output("single_req0_ready", 32'(req0_ready), 32'd1);
      check_output("single_req1_ready", 32'(req1_ready), 32'd0);
      tick();
      apply_stimulus(0, 0, 0, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 1);
      check_output("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check_output("single_rsp0_result", rsp0_result, 32'd12);
      check_output("single_rsp1_valid", 32'(rsp1_valid), 32'd0);

      // Contention right after reset: requester 0 wins first, then alternation
      do_reset();
      ca0 = 32'd100; cb0 = 32'd1; ca1 = 32'hAAAA_5555; cb1 = 32'd9;
      apply_stimulus(1, 10, 3, ALU_SUB, 1, 32'h8000_0000, 4, ALU_SRA, 1, 1);
      check_output("cont_first_ready0", 32'(req0_ready), 32'd1);
      check_output("cont_first_ready1", 32'(req1_ready), 32'd0);
      tick();
      check_output("cont_sub_result", rsp0_result, 32'd7);
      apply_stimulus(1, ca0, cb0, ALU_ADD, 1, 32'h8000_0000, 4, ALU_SRA, 1, 1);
      check_output("cont_second_ready1", 32'(req1_ready), 32'd1);
      check_output("cont_second_ready0", 32'(req0_ready), 32'd0);
      tick();
      check_output("cont_sra_result", rsp1_result, 32'hF800_0000);
      for (int k = 0; k < 6; k++) begin
         apply_stimulus(1, ca0, cb0, ALU_ADD, 1, ca1, cb1, ALU_XOR, 1, 1);
         check_output("alt_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         check_output("alt_ready1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         if (k % 2 == 0) begin
            check_output("alt_rsp0_result", rsp0_result, alu_model(ca0, cb0, ALU_ADD));
            ca0 = ca0 + 32'd3;
         end else begin
            check_output("alt_rsp1_result", rsp1_result, alu_model(ca1, cb1, ALU_XOR));
            cb1 = cb1 + 32'd5;
         end
      end
      apply_stimulus(0, 0, 0, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 1);
      tick();

      // Backpressure on response 0 blocks a new request 0
      apply_stimulus(1, 1, 1, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 1);
      tick();
      check_output("bp_first_result", rsp0_result, 32'd2);
      apply_stimulus(1, 32'hFF, 32'h0F, ALU_XOR, 0, 0, 0, ALU_ADD, 0, 1);
      check_output("bp_blocked_ready", 32'(req0_ready), 32'd0);
      tick();
      check_output("bp_hold_valid", 32'(rsp0_valid), 32'd1);
      check_output("bp_hold_result", rsp0_result, 32'd2);
      apply_stimulus(1, 32'hFF, 32'h0F, ALU_XOR, 0, 0, 0, ALU_ADD, 1, 1);
      check_output("bp_release_ready", 32'(req0_ready), 32'd1);
      tick();
      check_output("bp_xor_valid", 32'(rsp0_valid), 32'd1);
      check_output("bp_xor_result", rsp0_result, 32'hF0);

      // Back-to-back streaming on requester 1
      apply_stimulus(0, 0, 0, ALU_ADD, 1, 1, 2, ALU_SLTU, 1, 1);
      check_output("stream_ready_a", 32'(req1_ready), 32'd1);
      tick();
      check_output("stream_valid_a", 32'(rsp1_valid), 32'd1);
      check_output("stream_result_a", rsp1_result, 32'd1);
      apply_stimulus(0, 0, 0, ALU_ADD, 1, 3, 2, ALU_SLTU, 1, 1);
      check_output("stream_ready_b", 32'(req1_ready), 32'd1);
      tick();
      check_output("stream_valid_b", 32'(rsp1_valid), 32'd1);
      check_output("stream_result_b", rsp1_result, 32'd0);
      apply_stimulus(0, 0, 0, ALU_ADD, 1, 32'hFFFF_FFFF, 1, ALU_SLTU, 1, 1);
      check_output("stream_ready_c", 32'(req1_ready), 32'd1);
      tick();
      check_output("stream_valid_c", 32'(rsp1_valid), 32'd1);
      check_output("stream_result_c", rsp1_result, 32'd0);

      // Illegal op and LUI
      apply_stimulus(1, 123, 456, 4'b1111, 0, 0, 0, ALU_ADD, 1, 1);
      tick();
      check_output("illegal_op_result", rsp0_result, 32'd0);
      check_output("illegal_op_valid", 32'(rsp0_valid), 32'd1);
      apply_stimulus(1, 32'hDEAD_BEEF, 32'h1234_5000, ALU_LUI, 0, 0, 0, ALU_ADD, 1, 1);
      tick();
      check_output("lui_result", rsp0_result, 32'h1234_5000);

      // Asynchronous reset mid-operation discards the in-flight grant
      apply_stimulus(1, 4, 4, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 1);
      tick();
      check_output("midrst_pre_valid0", 32'(rsp0_valid), 32'd1);
      apply_stimulus(0, 0, 0, ALU_ADD, 1, 6, 6, ALU_ADD, 0, 1);
      check_output("midrst_req1_ready", 32'(req1_ready), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check_output("midrst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      check_output("midrst_rsp0_result", rsp0_result, 32'd0);
      check_output("midrst_ready_low", 32'(req1_ready), 32'd0);
      tick();
      check_output("midrst_discard", 32'(rsp1_valid), 32'd0);
      rst_n = 1'b1;
      apply_stimulus(1, 1, 2, ALU_OR, 1, 3, 4, ALU_OR, 1, 1);
      check_output("midrst_prio_ready0", 32'(req0_ready), 32'd1);
      check_output("midrst_prio_ready1", 32'(req1_ready), 32'd0);
      tick();
      check_output("midrst_prio_result", rsp0_result, 32'd3);

      // Randomized traffic against the behavioural model
      do_reset();
      last = 1;
      for (int i = 0; i < 2; i++) begin
         pend_v[i] = 1'b0; full[i] = 1'b0; data[i] = '0;
         pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = ALU_ADD;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend_v[i] && $urandom_range(0, 3) != 0) begin
               pend_v[i]  = 1'b1;
               pend_a[i]  = $urandom;
               pend_b[i]  = $urandom;
               pend_op[i] = op_list[$urandom_range(0, 11)];
            end
            rr[i] = ($urandom_range(0, 3) != 0);
         end
         apply_stimulus(pend_v[0], pend_a[0], pend_b[0], pend_op[0],
                        pend_v[1], pend_a[1], pend_b[1], pend_op[1], rr[0], rr[1]);
         check_output("rand_rsp0_valid", 32'(rsp0_valid), 32'(full[0]));
         check_output("rand_rsp1_valid", 32'(rsp1_valid), 32'(full[1]));
         if (full[0]) check_output("rand_rsp0_result", rsp0_result, data[0]);
         if (full[1]) check_output("rand_rsp1_result", rsp1_result, data[1]);
         for (int i = 0; i < 2; i++) elig[i] = pend_v[i] && (!full[i] || rr[i]);
         if (elig[0] && elig[1]) win = 1 - last;
         else if (elig[0])       win = 0;
         else if (elig[1])       win = 1;
         else                    win = -1;
         check_output("rand_req0_ready", 32'(req0_ready), (win == 0) ? 32'd1 : 32'd0);
         check_output("rand_req1_ready", 32'(req1_ready), (win == 1) ? 32'd1 : 32'd0);
         tick();
         for (int i = 0; i < 2; i++) begin
            if (win == i) begin
               full[i]   = 1'b1;
               data[i]   = alu_model(pend_a[i], pend_b[i], pend_op[i]);
               pend_v[i] = 1'b0;
               last      = i;
            end else if (full[i] && rr[i]) begin
               full[i] = 1'b0;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
